// File: rtl/ps_kernel_pkg.sv
// Shared types and constants for the 3x3 window controller and its row mux.
package ps_kernel_pkg;

  localparam int NUM_LB = 4;
  localparam int ROW_W  = 24;

  typedef logic [1:0] lb_sel_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_LINE = 1'b1
  } rd_state_t;

  // Buffer index arithmetic wraps naturally in the 2-bit select.
  function automatic lb_sel_t lb_next(input lb_sel_t sel, input logic [1:0] k);
    return lb_sel_t'(sel + k);
  endfunction

  function automatic logic [NUM_LB-1:0] lb_onehot(input lb_sel_t sel);
    return NUM_LB'(1) << sel;
  endfunction

endpackage

// File: rtl/ps_kernel_rowmux.sv
// Reorders the three active linebuffer outputs into a registered {top,mid,bot}
// window, with the read select delayed to line up with linebuffer read latency.
module ps_kernel_rowmux
  import ps_kernel_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_i,
  input  logic                 last_i,
  input  logic [1:0]           sel_i,
  input  logic [ROW_W-1:0]     rdata0_i,
  input  logic [ROW_W-1:0]     rdata1_i,
  input  logic [ROW_W-1:0]     rdata2_i,
  input  logic [ROW_W-1:0]     rdata3_i,
  output logic                 valid_o,
  output logic [3*ROW_W-1:0]   data_o,
  output logic                 line_done_o
);

  logic [ROW_W-1:0] rows [NUM_LB];
  logic             vld_p0;
  logic             last_p0;
  lb_sel_t          sel_p0;
  logic             vld_p1;
  logic             done_p1;
  logic [3*ROW_W-1:0] data_p1;

  assign rows[0] = rdata0_i;
  assign rows[1] = rdata1_i;
  assign rows[2] = rdata2_i;
  assign rows[3] = rdata3_i;

  // Stage p0: strobe cycle -> linebuffer data cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= rd_i;
      last_p0 <= last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    sel_p0 <= lb_sel_t'(sel_i);
  end

  // Stage p1: registered window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      done_p1 <= vld_p0 & last_p0;
      if (vld_p0) begin
        data_p1 <= {rows[sel_p0],
                    rows[lb_next(sel_p0, 2'd1)],
                    rows[lb_next(sel_p0, 2'd2)]};
      end
    end
  end

  assign valid_o     = vld_p1;
  assign line_done_o = done_p1;
  assign data_o      = data_p1;

endmodule

// File: rtl/ps_kernel_ctrl.sv
// Steers a raster pixel stream into four linebuffers and reads the three oldest
// complete lines in lockstep to form 3x3 windows for the convolution kernel.
module ps_kernel_ctrl
  import ps_kernel_pkg::*;
#(
  parameter int LINE_LENGTH = 640
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic [3:0]  o_lb_wr,
  output logic [7:0]  o_lb_wdata,
  output logic [3:0]  o_lb_rd,
  input  logic [23:0] i_lb_rdata0,
  input  logic [23:0] i_lb_rdata1,
  input  logic [23:0] i_lb_rdata2,
  input  logic [23:0] i_lb_rdata3,
  output logic        o_valid,
  output logic [71:0] o_data,
  output logic        o_line_done
);

  localparam int CNT_W = $clog2(LINE_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_LENGTH - 1);

  lb_sel_t          wr_sel_q, wr_sel_d;
  lb_sel_t          rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [2:0]       filled_q, filled_d;
  rd_state_t        state_q, state_d;

  logic xfer;
  logic wr_last;
  logic rd_active;
  logic rd_last;

  // With four unread lines the next write target is the oldest line still being read.
  assign o_ready   = (filled_q != 3'd4);
  assign xfer      = i_valid && o_ready;
  assign wr_last   = xfer && (wr_cnt_q == CNT_LAST);
  assign rd_active = (state_q == RD_LINE);
  assign rd_last   = rd_active && (rd_cnt_q == CNT_LAST);

  assign o_lb_wr    = xfer ? lb_onehot(wr_sel_q) : '0;
  assign o_lb_wdata = i_data;
  assign o_lb_rd    = rd_active ? (lb_onehot(rd_sel_q)
                                   | lb_onehot(lb_next(rd_sel_q, 2'd1))
                                   | lb_onehot(lb_next(rd_sel_q, 2'd2))) : '0;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    if (xfer) begin
      if (wr_last) begin
        wr_cnt_d = '0;
        wr_sel_d = lb_next(wr_sel_q, 2'd1);
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // The mandatory idle cycle after each line gives filled time to settle before re-arming.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    rd_sel_d = rd_sel_q;
    unique case (state_q)
      RD_IDLE: begin
        if (filled_q >= 3'd3) state_d = RD_LINE;
      end
      RD_LINE: begin
        if (rd_last) begin
          state_d  = RD_IDLE;
          rd_cnt_d = '0;
          rd_sel_d = lb_next(rd_sel_q, 2'd1);
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    unique case ({wr_last, rd_last})
      2'b10:   filled_d = filled_q + 3'd1;
      2'b01:   filled_d = filled_q - 3'd1;
      default: filled_d = filled_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_sel_q <= '0;
      wr_cnt_q <= '0;
      rd_sel_q <= '0;
      rd_cnt_q <= '0;
      filled_q <= '0;
      state_q  <= RD_IDLE;
    end else begin
      wr_sel_q <= wr_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_sel_q <= rd_sel_d;
      rd_cnt_q <= rd_cnt_d;
      filled_q <= filled_d;
      state_q  <= state_d;
    end
  end

  ps_kernel_rowmux u_rowmux (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .rd_i        (rd_active),
    .last_i      (rd_last),
    .sel_i       (rd_sel_q),
    .rdata0_i    (i_lb_rdata0),
    .rdata1_i    (i_lb_rdata1),
    .rdata2_i    (i_lb_rdata2),
    .rdata3_i    (i_lb_rdata3),
    .valid_o     (o_valid),
    .data_o      (o_data),
    .line_done_o (o_line_done)
  );

endmodule

// File: tb/tb_ps_kernel_ctrl.sv
// Bench for ps_kernel_ctrl with LINE_LENGTH=8, behavioural linebuffers and a
// line-level reference model of window contents and strobe timing.
module tb_ps_kernel_ctrl;

  localparam int LL = 8;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        o_ready;
  logic [3:0]  o_lb_wr;
  logic [7:0]  o_lb_wdata;
  logic [3:0]  o_lb_rd;
  logic        o_valid;
  logic [71:0] o_data;
  logic        o_line_done;
  logic [23:0] lb_rdata [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps_kernel_ctrl #(.LINE_LENGTH(LL)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_lb_wr     (o_lb_wr),
    .o_lb_wdata  (o_lb_wdata),
    .o_lb_rd     (o_lb_rd),
    .i_lb_rdata0 (lb_rdata[0]),
    .i_lb_rdata1 (lb_rdata[1]),
    .i_lb_rdata2 (lb_rdata[2]),
    .i_lb_rdata3 (lb_rdata[3]),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_line_done (o_line_done)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Behavioural linebuffers: one-cycle registered read of {p[n],p[n+1],p[n+2]}.
  logic [7:0] lbmem [4][LL];
  int lb_wp [4];
  int lb_rp [4];
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (i_rst) begin
        lb_wp[n] <= 0;
        lb_rp[n] <= 0;
      end else begin
        if (o_lb_wr[n]) begin
          lbmem[n][lb_wp[n]] <= o_lb_wdata;
          lb_wp[n] <= (lb_wp[n] + 1) % LL;
        end
        if (o_lb_rd[n]) begin
          lb_rdata[n] <= {lbmem[n][lb_rp[n]], lbmem[n][(lb_rp[n] + 1) % LL],
                          lbmem[n][(lb_rp[n] + 2) % LL]};
          lb_rp[n] <= (lb_rp[n] + 1) % LL;
        end
      end
    end
  end

  // Reference model: lines counted since reset, pixels stored per stream line.
  logic [7:0]  pix [64][LL];
  int unsigned lw, lr, wpos, rpos;
  bit          rbusy, live;
  bit          h1_v, h2_v;
  int          h1_l, h1_p, h2_l, h2_p;
  int          n_valid, ready_low;
  logic [3:0]  prev_rd;
  logic        prev_v;
  logic [3:0]  rd_masks [$];
  logic [71:0] first_win [$];

  function automatic logic [3:0] rd_mask(input int k);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) m[(k + i) % 4] = 1'b1;
    return m;
  endfunction

  function automatic logic [71:0] win(input int l, input int p);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[71 - 8*(3*r + c) -: 8] = pix[(l + r) % 64][(p + c) % LL];
    return w;
  endfunction

  always @(negedge clk) begin
    int   filled;
    logic xfer;
    if (live) begin
      filled = int'(lw) - int'(lr);
      xfer = i_valid && (filled != 4);
      chk("ready", o_ready, filled != 4);
      chk("wr_strobe", o_lb_wr, xfer ? (4'b0001 << (lw % 4)) : 4'b0000);
      if (xfer) chk("wdata", o_lb_wdata, i_data);
      chk("overlap", o_lb_wr & o_lb_rd, 0);
      chk("rd_strobe", o_lb_rd, rbusy ? rd_mask(lr) : 4'b0000);
      chk("valid", o_valid, h2_v);
      if (h2_v) begin
        chk("window", o_data, win(h2_l, h2_p));
        chk("line_done", o_line_done, h2_p == LL - 1);
      end else begin
        chk("line_done_idle", o_line_done, 0);
      end
      if (o_lb_rd != 4'b0000 && prev_rd == 4'b0000) rd_masks.push_back(o_lb_rd);
      if (o_valid === 1'b1) begin
        n_valid++;
        if (prev_v !== 1'b1) first_win.push_back(o_data);
      end
      if (o_ready === 1'b0) ready_low++;
      prev_rd = o_lb_rd;
      prev_v  = o_valid;
      h2_v = h1_v; h2_l = h1_l; h2_p = h1_p;
      h1_v = rbusy; h1_l = int'(lr); h1_p = int'(rpos);
      if (xfer) begin
        pix[lw % 64][wpos] = i_data;
        wpos++;
        if (wpos == LL) begin wpos = 0; lw++; end
      end
      if (rbusy) begin
        rpos++;
        if (rpos == LL) begin rpos = 0; lr++; rbusy = 0; end
      end else if (filled >= 3) begin
        rbusy = 1;
      end
    end
    if (i_rst) begin
      lw = 0; lr = 0; wpos = 0; rpos = 0; rbusy = 0;
      h1_v = 0; h2_v = 0;
      n_valid = 0; ready_low = 0; prev_rd = '0; prev_v = 1'b0;
      rd_masks.delete();
      first_win.delete();
      live = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    i_valid = 1'b0;
    i_rst = 1'b1;
    repeat (n) cyc();
    i_rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    logic acc;
    acc = 1'b0;
    i_valid = 1'b1;
    i_data  = v;
    for (int g = 0; g < 100 && !acc; g++) begin
      @(negedge clk);
      acc = o_ready;
      cyc();
    end
    chk("send_accepted", acc, 1);
    i_valid = 1'b0;
  endtask

  logic [7:0] sent [64];

  initial begin
    int   n;
    logic found;

    // Reset values
    do_reset(3);
    @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_wr", o_lb_wr, 0);
    chk("rst_rd", o_lb_rd, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_line_done", o_line_done, 0);
    cyc();

    // Fill three lines and check the first window
    for (int i = 0; i < 24; i++) begin
      sent[i] = 8'(i + 1);
      send(sent[i]);
    end
    found = 1'b0;
    for (int g = 0; g < 20 && !found; g++) begin
      @(negedge clk);
      found = (o_lb_rd == 4'b0111);
    end
    chk("first_rd_seen", found, 1);
    @(negedge clk);
    @(negedge clk);
    chk("first_valid", o_valid, 1);
    chk("first_window", o_data, 72'h010203_090A0B_111213);
    n = 1;
    for (int g = 0; g < 20 && o_line_done !== 1'b1; g++) begin
      @(negedge clk);
      if (o_valid === 1'b1) n++;
    end
    chk("line0_windows", n, LL);
    @(negedge clk);
    chk("line_gap", o_valid, 0);
    cyc();

    // Rotation through all four buffers
    for (int i = 24; i < 64; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      send(sent[i]);
    end
    repeat (60) cyc();
    chk("rot_mask0", rd_masks[0], 4'b0111);
    chk("rot_mask1", rd_masks[1], 4'b1110);
    chk("rot_mask2", rd_masks[2], 4'b1101);
    chk("rot_top1", first_win[1][71:48], 24'h090A0B);
    chk("rot_wrap2", first_win[2], {sent[16], sent[17], sent[18], sent[24], sent[25],
                                    sent[26], sent[32], sent[33], sent[34]});
    chk("rot_windows", n_valid, 6 * LL);

    // Backpressure: 33 back-to-back pixels, the last one must wait for buffer 0
    do_reset(2);
    for (int i = 0; i < 33; i++) send(8'($urandom_range(0, 255)));
    repeat (30) cyc();
    chk("bp_ready_low_cycles", ready_low, 1);

    // Simultaneous write-line and read-line completion
    do_reset(2);
    for (int i = 0; i < 24; i++) send(8'($urandom_range(0, 255)));
    cyc();
    for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)));
    repeat (30) cyc();
    chk("sim_ready_low_cycles", ready_low, 0);
    chk("sim_reads", rd_masks.size(), 2);
    chk("sim_next_mask", rd_masks[1], 4'b1110);

    // Reset in the middle of a read line
    do_reset(2);
    for (int i = 0; i < 24; i++) send(8'($urandom_range(0, 255)));
    n = 0;
    for (int g = 0; g < 20 && n < 3; g++) begin
      @(negedge clk);
      if (o_lb_rd != 4'b0000) n++;
    end
    chk("mid_rd_reached", n, 3);
    cyc();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_rd", o_lb_rd, 0);
    cyc();
    for (int i = 0; i < 23; i++) send(8'($urandom_range(0, 255)));
    repeat (20) cyc();
    chk("mid_no_early_window", n_valid, 0);
    chk("mid_no_early_read", rd_masks.size(), 0);
    send(8'($urandom_range(0, 255)));
    found = 1'b0;
    for (int g = 0; g < 10 && !found; g++) begin
      @(negedge clk);
      found = (o_valid === 1'b1);
    end
    chk("mid_new_window", found, 1);
    repeat (20) cyc();

    // Randomised traffic with gaps
    do_reset(2);
    for (int i = 0; i < 30 * LL; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc();
      send(8'($urandom_range(0, 255)));
    end
    repeat (60) cyc();
    chk("rand_windows", n_valid, 28 * LL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
